// File: rtl/controlador_revelado.sv
// Reveal controller for an 8x8 minesweeper board with a same-cycle read port.
// Define REVEAL_CASCADE_EN to enable the flood-fill cascade from zero-count cells.
module controlador_revelado (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] i_sel,
    input  logic [2:0] j_sel,
    output logic [5:0] cell_addr,
    input  logic [6:0] cell_rdata,
    output logic       cell_we,
    output logic [6:0] cell_wdata,
    output logic       busy,
    output logic       done,
    output logic       hit_bomb,
    output logic [6:0] revealed_count
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROOT  = 3'd1,
        S_POP   = 3'd2,
        S_NEIGH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] root_q, root_d;
    logic       hit_q, hit_d;
    logic [6:0] cnt_q, cnt_d;
    logic       we_s;
    logic [5:0] addr_s;
    logic       cell_free_s;

    assign cell_free_s = ~cell_rdata[6] & ~cell_rdata[5];

`ifdef REVEAL_CASCADE_EN
    logic [5:0] q_mem [0:63];
    logic [5:0] head_q, head_d, tail_q, tail_d;
    logic [6:0] qcnt_q, qcnt_d;
    logic       push_s;
    logic [5:0] push_addr_s;
    logic [2:0] cur_i_q, cur_i_d, cur_j_q, cur_j_d, n_q, n_d;
    logic [3:0] di_s, dj_s, ni_s, nj_s;
    logic       on_board_s;

    // Neighbour offsets; a 4-bit sum with bit3 set means the neighbour fell off the board
    always_comb begin
        di_s = 4'h0;
        dj_s = 4'h0;
        case (n_q)
            3'd0:    begin di_s = 4'hF; dj_s = 4'hF; end
            3'd1:    begin di_s = 4'hF; dj_s = 4'h0; end
            3'd2:    begin di_s = 4'hF; dj_s = 4'h1; end
            3'd3:    begin di_s = 4'h0; dj_s = 4'hF; end
            3'd4:    begin di_s = 4'h0; dj_s = 4'h1; end
            3'd5:    begin di_s = 4'h1; dj_s = 4'hF; end
            3'd6:    begin di_s = 4'h1; dj_s = 4'h0; end
            default: begin di_s = 4'h1; dj_s = 4'h1; end
        endcase
        ni_s       = {1'b0, cur_i_q} + di_s;
        nj_s       = {1'b0, cur_j_q} + dj_s;
        on_board_s = ~ni_s[3] & ~nj_s[3];
    end

    // Queue storage; written only in the cycle a zero-count cell is revealed
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_mem[tail_q] <= push_addr_s;
        end
    end

    // Queue pointers, current cell and neighbour index
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= 6'd0;
            tail_q  <= 6'd0;
            qcnt_q  <= 7'd0;
            cur_i_q <= 3'd0;
            cur_j_q <= 3'd0;
            n_q     <= 3'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            qcnt_q  <= qcnt_d;
            cur_i_q <= cur_i_d;
            cur_j_q <= cur_j_d;
            n_q     <= n_d;
        end
    end
`endif

    // Control state and operation results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            root_q  <= 6'd0;
            hit_q   <= 1'b0;
            cnt_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            root_q  <= root_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, board access and queue control
    always_comb begin
        state_d = state_q;
        root_d  = root_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        addr_s  = 6'd0;
`ifdef REVEAL_CASCADE_EN
        head_d      = head_q;
        tail_d      = tail_q;
        qcnt_d      = qcnt_q;
        cur_i_d     = cur_i_q;
        cur_j_d     = cur_j_q;
        n_d         = n_q;
        push_s      = 1'b0;
        push_addr_s = 6'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    root_d  = {i_sel, j_sel};
                    hit_d   = 1'b0;
                    cnt_d   = 7'd0;
                    state_d = S_ROOT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROOT: begin
                addr_s  = root_q;
                state_d = S_DONE;
                if (!cell_free_s) begin
                    we_s = 1'b0;
                end else if (cell_rdata[4]) begin
                    we_s  = 1'b1;
                    hit_d = 1'b1;
                end else begin
                    we_s  = 1'b1;
                    cnt_d = cnt_q + 7'd1;
`ifdef REVEAL_CASCADE_EN
                    if (cell_rdata[3:0] == 4'd0) begin
                        push_s      = 1'b1;
                        push_addr_s = root_q;
                        tail_d      = tail_q + 6'd1;
                        qcnt_d      = qcnt_q + 7'd1;
                        state_d     = S_POP;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef REVEAL_CASCADE_EN
            S_POP: begin
                if (qcnt_q == 7'd0) begin
                    state_d = S_DONE;
                end else begin
                    cur_i_d = q_mem[head_q][5:3];
                    cur_j_d = q_mem[head_q][2:0];
                    head_d  = head_q + 6'd1;
                    qcnt_d  = qcnt_q - 7'd1;
                    n_d     = 3'd0;
                    state_d = S_NEIGH;
                end
            end
            S_NEIGH: begin
                addr_s = {ni_s[2:0], nj_s[2:0]};
                if (on_board_s && cell_free_s && !cell_rdata[4]) begin
                    we_s  = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                    if (cell_rdata[3:0] == 4'd0) begin
                        push_s      = 1'b1;
                        push_addr_s = addr_s;
                        tail_d      = tail_q + 6'd1;
                        qcnt_d      = qcnt_q + 7'd1;
                    end else begin
                        push_s = 1'b0;
                    end
                end else begin
                    we_s = 1'b0;
                end
                n_d = n_q + 3'd1;
                if (n_q == 3'd7) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_NEIGH;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cell_addr      = addr_s;
    assign cell_we        = we_s & ~rst;
    assign cell_wdata     = cell_rdata | 7'h40;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign hit_bomb       = hit_q;
    assign revealed_count = cnt_q;
endmodule

// File: tb/tb_controlador_revelado.sv
// Bench for controlador_revelado: fixed vectors, hand sequences and random boards
// checked against a breadth-first flood-fill reference model.
module tb_controlador_revelado;
`ifdef REVEAL_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] i_sel, j_sel;
    logic [5:0] cell_addr;
    logic [6:0] cell_rdata;
    logic       cell_we;
    logic [6:0] cell_wdata;
    logic       busy, done, hit_bomb;
    logic [6:0] revealed_count;

    logic [6:0] board      [0:63];
    logic [6:0] init_board [0:63];
    logic [6:0] mb         [0:63];
    logic       fill_req;
    int         wr_count, dup_count, first_addr, first_data;
    int         n_checks = 0;
    int         n_fail   = 0;

    controlador_revelado dut (
        .clk(clk), .rst(rst), .start(start), .i_sel(i_sel), .j_sel(j_sel),
        .cell_addr(cell_addr), .cell_rdata(cell_rdata), .cell_we(cell_we),
        .cell_wdata(cell_wdata), .busy(busy), .done(done), .hit_bomb(hit_bomb),
        .revealed_count(revealed_count)
    );

    always #5 clk = ~clk;

    assign cell_rdata = board[cell_addr];

    // Board memory: loads a staged image on request, otherwise captures DUT writes
    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < 64; k++) board[k] <= init_board[k];
            wr_count   <= 0;
            dup_count  <= 0;
            first_addr <= -1;
            first_data <= -1;
        end else if (cell_we) begin
            if (board[cell_addr][6]) dup_count <= dup_count + 1;
            if (wr_count == 0) begin
                first_addr <= int'(cell_addr);
                first_data <= int'(cell_wdata);
            end
            board[cell_addr] <= cell_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_fill();
        @(negedge clk); fill_req = 1'b1;
        @(negedge clk); fill_req = 1'b0;
    endtask

    // Starts an operation and returns the cycle (after the accept edge) in which done rose
    task automatic run_op(input int i, input int j, output int cyc);
        @(negedge clk);
        i_sel = 3'(i); j_sel = 3'(j); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Reference: reveal rules applied to mb, breadth-first flood from zero-count cells
    task automatic model_run(input int ri, input int rj, output int rc, output int hit, output int cyc);
        int q[$];
        int a, b, ni, nj, pops;
        bit pushed;
        logic [6:0] v;
        rc = 0; hit = 0; pops = 0; pushed = 1'b0;
        a = ri * 8 + rj;
        v = mb[a];
        if (!v[6] && !v[5]) begin
            mb[a] = v | 7'h40;
            if (v[4]) hit = 1;
            else begin
                rc = 1;
                if (CASC && v[3:0] == 4'd0) begin
                    q.push_back(a);
                    pushed = 1'b1;
                end
            end
        end
        while (q.size() > 0) begin
            a = q.pop_front();
            pops++;
            for (int di = -1; di <= 1; di++) begin
                for (int dj = -1; dj <= 1; dj++) begin
                    ni = a / 8 + di;
                    nj = a % 8 + dj;
                    if ((di != 0 || dj != 0) && ni >= 0 && ni < 8 && nj >= 0 && nj < 8) begin
                        b = ni * 8 + nj;
                        v = mb[b];
                        if (!v[6] && !v[5] && !v[4]) begin
                            mb[b] = v | 7'h40;
                            rc++;
                            if (v[3:0] == 4'd0) q.push_back(b);
                        end
                    end
                end
            end
        end
        cyc = pushed ? 3 + 9 * pops : 2;
    endtask

    task automatic check_against_model(input string tag, input int ri, input int rj);
        int erc, ehit, ecyc, cyc, bad;
        for (int k = 0; k < 64; k++) mb[k] = board[k];
        model_run(ri, rj, erc, ehit, ecyc);
        run_op(ri, rj, cyc);
        bad = 0;
        for (int k = 0; k < 64; k++) if (board[k] !== mb[k]) bad++;
        check({tag, "_cycle"}, cyc, ecyc);
        check({tag, "_count"}, int'(revealed_count), erc);
        check({tag, "_hit"}, int'(hit_bomb), ehit);
        check({tag, "_writes"}, wr_count, erc + ehit);
        check({tag, "_dup"}, dup_count, 0);
        check({tag, "_board"}, bad, 0);
    endtask

    typedef struct {
        logic [6:0] fill;
        int         sp_addr;
        logic [6:0] sp_val;
        int         i, j;
        int         rc, hit, cyc, writes, waddr, wdata;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   cyc, r;
        string nm;

        vecs[0] = '{7'h01, -1, 7'h00, 3, 4, 1, 0, 2, 1, 28, 'h41};
        vecs[1] = '{7'h01,  0, 7'h10, 0, 0, 0, 1, 2, 1,  0, 'h50};
        vecs[2] = '{7'h01, 45, 7'h20, 5, 5, 0, 0, 2, 0, -1, -1};
        vecs[3] = '{7'h41, -1, 7'h00, 6, 1, 0, 0, 2, 0, -1, -1};
`ifdef REVEAL_CASCADE_EN
        vecs[4] = '{7'h00, -1, 7'h00, 0, 0, 64, 0, 579, 64, 0, 'h40};
        vecs[5] = '{7'h00, -1, 7'h00, 2, 2, 64, 0, 579, 64, 18, 'h40};
`else
        vecs[4] = '{7'h00, -1, 7'h00, 0, 0, 1, 0, 2, 1, 0, 'h40};
        vecs[5] = '{7'h00, -1, 7'h00, 2, 2, 1, 0, 2, 1, 18, 'h40};
`endif

        rst = 1'b1; start = 1'b0; i_sel = 3'd0; j_sel = 3'd0; fill_req = 1'b0;
        for (int k = 0; k < 64; k++) init_board[k] = 7'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(cell_we), 0);
        check("rst_hit", int'(hit_bomb), 0);
        check("rst_count", int'(revealed_count), 0);
        check("rst_addr", int'(cell_addr), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 64; k++) init_board[k] = vecs[v].fill;
            if (vecs[v].sp_addr >= 0) init_board[vecs[v].sp_addr] = vecs[v].sp_val;
            apply_fill();
            run_op(vecs[v].i, vecs[v].j, cyc);
            nm = $sformatf("vec%0d", v);
            check({nm, "_cycle"}, cyc, vecs[v].cyc);
            check({nm, "_count"}, int'(revealed_count), vecs[v].rc);
            check({nm, "_hit"}, int'(hit_bomb), vecs[v].hit);
            check({nm, "_writes"}, wr_count, vecs[v].writes);
            check({nm, "_dup"}, dup_count, 0);
            if (vecs[v].writes > 0) begin
                check({nm, "_waddr"}, first_addr, vecs[v].waddr);
                check({nm, "_wdata"}, first_data, vecs[v].wdata);
            end
        end

        // start held high: ignored in DONE, accepted again from IDLE
        for (int k = 0; k < 64; k++) init_board[k] = 7'h01;
        apply_fill();
        @(negedge clk); i_sel = 3'd1; j_sel = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk); check("hold_busy_c1", int'(busy), 1);
        @(negedge clk); check("hold_done_c2", int'(done), 1);
        check("hold_count_c2", int'(revealed_count), 1);
        @(negedge clk); check("hold_idle_c3", int'(busy), 0);
        @(negedge clk); check("hold_busy_c4", int'(busy), 1);
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
        end
        check("hold_second_cycle", cyc, 1);
        check("hold_second_count", int'(revealed_count), 0);
        check("hold_writes", wr_count, 1);

        // reset in cycle 100 of a full-board operation, then a fresh start at (7,7)
        for (int k = 0; k < 64; k++) init_board[k] = 7'h00;
        apply_fill();
        @(negedge clk); i_sel = 3'd0; j_sel = 3'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) init_board[k] = board[k];
        apply_fill();
        check_against_model("after_rst", 7, 7);

        // random boards: bombs, flags, pre-revealed cells and frequent zero counts
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 64; k++) begin
                r = $urandom_range(0, 99);
                if (r < 12)      init_board[k] = 7'h10 | 7'($urandom_range(0, 8));
                else if (r < 17) init_board[k] = 7'h20 | 7'($urandom_range(0, 8));
                else if (r < 22) init_board[k] = 7'h40 | 7'($urandom_range(0, 8));
                else if ($urandom_range(0, 2) == 0) init_board[k] = 7'h00;
                else             init_board[k] = 7'($urandom_range(1, 8));
            end
            apply_fill();
            check_against_model($sformatf("rnd%0d", t), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
